// File: rtl/wb_addr_dec_if.sv
// Wishbone decoder bus bundle: CPU-facing cycle/strobe/address/response plus per-slave fan-out.
// Latency: none; wires only.
// Backpressure: none here; the slave acknowledge is the only flow control.
// Ports: cyc_i, stb_i, adr_i, ack_o, err_o, dat_o (CPU side); slv_stb_o, slv_ack_i, slv_dat_i (slave side).
// Modport 'slave' is the decoder's view; modport 'master' is the view of whatever drives it.
interface wb_addr_dec_if #(
  parameter int SLAVES = 4,
  parameter int ADDR_W = 30
);
  logic                   cyc_i;
  logic                   stb_i;
  logic [ADDR_W-1:0]      adr_i;
  logic                   ack_o;
  logic                   err_o;
  logic [31:0]            dat_o;
  logic [SLAVES-1:0]      slv_stb_o;
  logic [SLAVES-1:0]      slv_ack_i;
  logic [SLAVES*32-1:0]   slv_dat_i;

  modport slave (
    input  cyc_i, stb_i, adr_i, slv_ack_i, slv_dat_i,
    output ack_o, err_o, dat_o, slv_stb_o
  );

  modport master (
    output cyc_i, stb_i, adr_i, slv_ack_i, slv_dat_i,
    input  ack_o, err_o, dat_o, slv_stb_o
  );
endinterface

// File: rtl/wb_addr_dec.sv
// Wishbone address decoder: base/mask region match, registered slave strobe, ack, data and bus error.
// Latency: ack_o/err_o one cycle after the slave ack (two cycles after a request for zero-wait or unmapped).
// Backpressure: holds the selected strobe until the slave acks, the master drops cyc_i, or TIMEOUT expires.
// Ports: clk_i, rst_i (synchronous, active-high) and the 'bus' interface (slave modport) carrying
//        the CPU request/response signals and the per-slave strobe/ack/data lines.
module wb_addr_dec #(
  parameter int SLAVES  = 4,
  parameter int ADDR_W  = 30,
  parameter logic [SLAVES*ADDR_W-1:0] BASE =
    {30'h10000000, 30'h08000000, 30'h04000000, 30'h00000000},
  parameter logic [SLAVES*ADDR_W-1:0] MASK = {4{30'h3C000000}},
  parameter int TIMEOUT = 255
) (
  input logic          clk_i,
  input logic          rst_i,
  wb_addr_dec_if.slave bus
);

  localparam int IDX_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  // A zero TIMEOUT still needs a legal one-bit counter even though it is never compared.
  localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERR    = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [31:0]        dat_q, dat_d;
  logic [SLAVES-1:0]  stb_q, stb_d;

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic [SLAVES-1:0]  hit_onehot;
  logic               sel_ack;
  logic [31:0]        sel_dat;

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = SLAVES - 1; i >= 0; i--) begin
      if ((bus.adr_i & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    hit_onehot = '0;
    sel_ack    = 1'b0;
    sel_dat    = '0;
    for (int i = 0; i < SLAVES; i++) begin
      hit_onehot[i] = (hit_idx == IDX_W'(i));
      if (sel_q == IDX_W'(i)) begin
        sel_ack = bus.slv_ack_i[i];
        sel_dat = bus.slv_dat_i[i*32 +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    stb_d   = stb_q;

    case (state_q)
      IDLE: begin
        stb_d = '0;
        if (bus.cyc_i && bus.stb_i) begin
          if (hit) begin
            sel_d   = hit_idx;
            cnt_d   = '0;
            stb_d   = hit_onehot;
            state_d = ACTIVE;
          end else begin
            state_d = ERR;
          end
        end
      end

      ACTIVE: begin
        if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
        // An abandoned cycle gets no response even if the slave answers on the same edge.
        if (!bus.cyc_i) begin
          stb_d   = '0;
          state_d = IDLE;
        end else if (sel_ack) begin
          dat_d   = sel_dat;
          ack_d   = 1'b1;
          stb_d   = '0;
          state_d = RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          err_d   = 1'b1;
          stb_d   = '0;
          state_d = RESP;
        end
      end

      ERR: begin
        err_d   = 1'b1;
        state_d = RESP;
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        stb_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      stb_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      stb_q   <= stb_d;
    end
  end

  assign bus.ack_o     = ack_q;
  assign bus.err_o     = err_q;
  assign bus.dat_o     = dat_q;
  assign bus.slv_stb_o = stb_q;

endmodule

// File: tb/tb_wb_addr_dec.sv
module tb_wb_addr_dec;

  localparam int TO = 8;
  // Slave 1 is widened (mask drops bit 26) so it overlaps slave 0 at low addresses.
  localparam logic [29:0] BASE_T [4] = '{30'h00000000, 30'h00000000, 30'h08000000, 30'h10000000};
  localparam logic [29:0] MASK_T [4] = '{30'h3C000000, 30'h38000000, 30'h3C000000, 30'h3C000000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] sdat [4];

  int checks = 0;
  int errors = 0;
  logic [31:0] last_dat;

  typedef struct {
    int          n_stb;
    logic [3:0]  stb_or;
    bit          multi;
    int          n_ack;
    int          n_err;
    bit          both;
    logic [31:0] dat;
    int          pulse_cyc;
  } obs_t;

  always #5 clk = ~clk;

  wb_addr_dec_if #(.SLAVES(4), .ADDR_W(30)) bus ();

  wb_addr_dec #(
    .SLAVES (4),
    .ADDR_W (30),
    .BASE   ({30'h10000000, 30'h08000000, 30'h00000000, 30'h00000000}),
    .MASK   ({30'h3C000000, 30'h3C000000, 30'h38000000, 30'h3C000000}),
    .TIMEOUT(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always_comb bus.slv_dat_i = {sdat[3], sdat[2], sdat[1], sdat[0]};

  // Reference: first region (lowest index) whose masked address equals its base; -1 when unmapped.
  function automatic int target(input logic [29:0] a);
    for (int i = 0; i < 4; i++) begin
      if ((a & MASK_T[i]) == BASE_T[i]) return i;
    end
    return -1;
  endfunction

  // Drives one access and records what the decoder did. The slave answers on its
  // (w+1)-th strobe cycle; abort_at>0 drops cyc on that strobe cycle instead.
  // noise acks other slaves alongside. Two cycles after the response a stray ack on
  // every slave is injected, and any further pulse is recorded.
  task automatic do_access(input logic [29:0] a, input int w, input int abort_at,
                           input logic [3:0] noise, output obs_t o);
    int sc;
    int post;
    bit done;
    o.n_stb = 0; o.stb_or = '0; o.multi = 0; o.n_ack = 0; o.n_err = 0;
    o.both = 0; o.dat = '0; o.pulse_cyc = 0;
    sc = 0; post = 0; done = 0;
    @(negedge clk);
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.adr_i = a; bus.slv_ack_i = '0;
    for (int c = 1; c <= 40 && post < 4; c++) begin
      @(negedge clk);
      if (bus.slv_stb_o != '0) begin
        o.n_stb++;
        o.stb_or |= bus.slv_stb_o;
        if ($countones(bus.slv_stb_o) > 1) o.multi = 1;
        sc++;
      end
      if (bus.ack_o) begin
        o.n_ack++;
        o.dat = bus.dat_o;
        if (o.pulse_cyc == 0) o.pulse_cyc = c;
      end
      if (bus.err_o) begin
        o.n_err++;
        if (o.pulse_cyc == 0) o.pulse_cyc = c;
      end
      if (bus.ack_o && bus.err_o) o.both = 1;
      bus.slv_ack_i = '0;
      if (done) begin
        post++;
        if (post == 2) bus.slv_ack_i = '1;
      end else if (bus.ack_o || bus.err_o) begin
        done = 1; bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
      end else if (bus.slv_stb_o != '0) begin
        if (abort_at > 0 && sc == abort_at) begin
          bus.cyc_i = 1'b0; bus.stb_i = 1'b0; done = 1;
        end else if (sc == w + 1) begin
          bus.slv_ack_i = bus.slv_stb_o | noise;
        end else begin
          bus.slv_ack_i = noise & ~bus.slv_stb_o;
        end
      end
    end
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.slv_ack_i = '0;
  endtask

  task automatic test_reset();
    bus.cyc_i = 0; bus.stb_i = 0; bus.adr_i = '0; bus.slv_ack_i = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", bus.ack_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err_o); end
    checks++; if (bus.dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat got %h exp 0", bus.dat_o); end
    checks++; if (bus.slv_stb_o !== 4'h0) begin errors++; $display("FAIL reset_stb got %b exp 0000", bus.slv_stb_o); end
    rst = 1'b0;
    last_dat = 32'h0;
    @(negedge clk);
    checks++; if (bus.slv_stb_o !== 4'h0) begin errors++; $display("FAIL idle_stb got %b exp 0000", bus.slv_stb_o); end
  endtask

  task automatic test_basic_read();
    obs_t o;
    sdat[0] = 32'h11111111; sdat[1] = 32'hDEADBEEF; sdat[2] = 32'h22222222; sdat[3] = 32'h33333333;
    do_access(30'h04000010, 0, 0, 4'h0, o);
    last_dat = 32'hDEADBEEF;
    checks++; if (o.stb_or !== 4'b0010) begin errors++; $display("FAIL basic_stb got %b exp 0010", o.stb_or); end
    checks++; if (o.n_stb !== 1) begin errors++; $display("FAIL basic_nstb got %0d exp 1", o.n_stb); end
    checks++; if (o.n_ack !== 1 || o.n_err !== 0) begin errors++; $display("FAIL basic_resp got ack %0d err %0d exp 1 0", o.n_ack, o.n_err); end
    checks++; if (o.pulse_cyc !== 2) begin errors++; $display("FAIL basic_latency got %0d exp 2", o.pulse_cyc); end
    checks++; if (o.dat !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_dat got %h exp deadbeef", o.dat); end
  endtask

  task automatic test_unmapped();
    obs_t o;
    do_access(30'h20000000, 0, 0, 4'h0, o);
    checks++; if (o.n_stb !== 0) begin errors++; $display("FAIL unmap_stb got %0d cycles exp 0", o.n_stb); end
    checks++; if (o.n_err !== 1 || o.n_ack !== 0) begin errors++; $display("FAIL unmap_resp got ack %0d err %0d exp 0 1", o.n_ack, o.n_err); end
    checks++; if (o.pulse_cyc !== 2) begin errors++; $display("FAIL unmap_latency got %0d exp 2", o.pulse_cyc); end
    checks++; if (bus.dat_o !== last_dat) begin errors++; $display("FAIL unmap_dat_hold got %h exp %h", bus.dat_o, last_dat); end
  endtask

  task automatic test_timeout();
    obs_t o;
    do_access(30'h10000000, 1000, 0, 4'h0, o);
    checks++; if (o.stb_or !== 4'b1000 || o.n_stb !== TO) begin errors++; $display("FAIL to_stb got %b x%0d exp 1000 x%0d", o.stb_or, o.n_stb, TO); end
    checks++; if (o.n_err !== 1 || o.n_ack !== 0) begin errors++; $display("FAIL to_resp got ack %0d err %0d exp 0 1", o.n_ack, o.n_err); end
    checks++; if (o.pulse_cyc !== TO + 1) begin errors++; $display("FAIL to_latency got %0d exp %0d", o.pulse_cyc, TO + 1); end
    // Ack on the last allowed cycle beats the timeout.
    sdat[3] = 32'hCAFE0003;
    do_access(30'h10000000, TO - 1, 0, 4'h0, o);
    last_dat = 32'hCAFE0003;
    checks++; if (o.n_ack !== 1 || o.n_err !== 0 || o.dat !== 32'hCAFE0003) begin errors++; $display("FAIL to_edge_ack got ack %0d err %0d dat %h exp 1 0 cafe0003", o.n_ack, o.n_err, o.dat); end
  endtask

  task automatic test_priority();
    obs_t o;
    sdat[0] = 32'hA0A0A0A0;
    do_access(30'h00000004, 0, 0, 4'h0, o);
    last_dat = 32'hA0A0A0A0;
    checks++; if (o.stb_or !== 4'b0001) begin errors++; $display("FAIL prio_stb got %b exp 0001", o.stb_or); end
    checks++; if (o.dat !== 32'hA0A0A0A0) begin errors++; $display("FAIL prio_dat got %h exp a0a0a0a0", o.dat); end
  endtask

  task automatic test_abort();
    obs_t o;
    do_access(30'h10000000, 1000, 3, 4'h0, o);
    checks++; if (o.n_stb !== 3) begin errors++; $display("FAIL abort_stb got %0d cycles exp 3", o.n_stb); end
    checks++; if (o.n_ack !== 0 || o.n_err !== 0) begin errors++; $display("FAIL abort_resp got ack %0d err %0d exp 0 0", o.n_ack, o.n_err); end
    sdat[2] = 32'h0BADF00D;
    do_access(30'h08000000, 1, 0, 4'h0, o);
    last_dat = 32'h0BADF00D;
    checks++; if (o.stb_or !== 4'b0100 || o.n_ack !== 1 || o.dat !== 32'h0BADF00D) begin errors++; $display("FAIL after_abort got stb %b ack %0d dat %h exp 0100 1 0badf00d", o.stb_or, o.n_ack, o.dat); end
    checks++; if (o.pulse_cyc !== 3) begin errors++; $display("FAIL after_abort_latency got %0d exp 3", o.pulse_cyc); end
  endtask

  task automatic test_sim_ack();
    obs_t o;
    sdat[0] = 32'h00000BAD; sdat[2] = 32'h600D0002;
    do_access(30'h08000100, 2, 0, 4'b0001, o);
    last_dat = 32'h600D0002;
    checks++; if (o.n_ack !== 1 || o.dat !== 32'h600D0002) begin errors++; $display("FAIL simack got ack %0d dat %h exp 1 600d0002", o.n_ack, o.dat); end
    checks++; if (o.n_stb !== 3) begin errors++; $display("FAIL simack_stb got %0d cycles exp 3", o.n_stb); end
  endtask

  task automatic test_rst_mid();
    int n;
    n = 0;
    @(negedge clk);
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.adr_i = 30'h08000000;
    @(negedge clk);
    checks++; if (bus.slv_stb_o !== 4'b0100) begin errors++; $display("FAIL rstmid_stb got %b exp 0100", bus.slv_stb_o); end
    rst = 1'b1; bus.slv_ack_i = 4'b0100;
    @(negedge clk);
    rst = 1'b0; bus.slv_ack_i = '0; bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    checks++; if ({bus.ack_o, bus.err_o, bus.slv_stb_o} !== 6'b0 || bus.dat_o !== 32'h0) begin errors++; $display("FAIL rstmid_out got ack %b err %b stb %b dat %h exp all 0", bus.ack_o, bus.err_o, bus.slv_stb_o, bus.dat_o); end
    repeat (4) begin
      @(negedge clk);
      if (bus.ack_o || bus.err_o || bus.slv_stb_o != 0) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL rstmid_quiet got %0d active cycles exp 0", n); end
    last_dat = 32'h0;
  endtask

  task automatic test_random();
    obs_t o;
    logic [29:0] a;
    logic [3:0] top;
    int w, t, exp_nstb;
    bit exp_ack;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 4))
        0: top = 4'd0;
        1: top = 4'd1;
        2: top = 4'd2;
        3: top = 4'd4;
        default: top = 4'($urandom_range(0, 15));
      endcase
      a = {top, 26'($urandom)};
      w = $urandom_range(0, TO + 1);
      for (int i = 0; i < 4; i++) sdat[i] = $urandom;
      t = target(a);
      do_access(a, w, 0, 4'($urandom), o);
      exp_nstb = (t < 0) ? 0 : ((w + 1 < TO) ? w + 1 : TO);
      exp_ack  = (t >= 0) && (w + 1 <= TO);
      checks++; if (o.n_stb !== exp_nstb || o.multi) begin errors++; $display("FAIL rnd%0d_nstb adr %h got %0d multi %b exp %0d", k, a, o.n_stb, o.multi, exp_nstb); end
      checks++; if (t >= 0 && o.stb_or !== 4'(1 << t)) begin errors++; $display("FAIL rnd%0d_sel adr %h got %b exp slave %0d", k, a, o.stb_or, t); end
      checks++; if (o.n_ack !== int'(exp_ack) || o.n_err !== int'(!exp_ack) || o.both) begin errors++; $display("FAIL rnd%0d_resp adr %h got ack %0d err %0d exp ack %0d", k, a, o.n_ack, o.n_err, exp_ack); end
      checks++; if (o.pulse_cyc !== ((t < 0) ? 2 : exp_nstb + 1)) begin errors++; $display("FAIL rnd%0d_latency got %0d exp %0d", k, o.pulse_cyc, (t < 0) ? 2 : exp_nstb + 1); end
      if (exp_ack) last_dat = sdat[t];
      checks++; if (bus.dat_o !== last_dat) begin errors++; $display("FAIL rnd%0d_dat got %h exp %h", k, bus.dat_o, last_dat); end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) sdat[i] = '0;
    bus.cyc_i = 0; bus.stb_i = 0; bus.adr_i = '0; bus.slv_ack_i = '0;
    last_dat = '0;
    test_reset();
    test_basic_read();
    test_unmapped();
    test_timeout();
    test_priority();
    test_abort();
    test_sim_ack();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
